// File: rtl/dds_mux_pkg.sv
// Shared types and constants for the round-robin sample-mux scheduler.
package dds_mux_pkg;

  localparam int NUM_REQ = 8;
  localparam int SEL_W   = 3;

  typedef logic [SEL_W-1:0] sel_t;

  typedef enum logic {
    IDLE,
    GRANT
  } sched_state_t;

  function automatic logic [NUM_REQ-1:0] onehot(sel_t s);
    return {{(NUM_REQ-1){1'b0}}, 1'b1} << s;
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin pick: first set bit of mask searching ptr, ptr+1, ... mod NUM_REQ.
module rr_priority_pick
  import dds_mux_pkg::*;
(
  input  logic [NUM_REQ-1:0] mask,
  input  sel_t               ptr,
  output sel_t               idx,
  output logic               found
);

  // Walk from the farthest offset back to ptr so the closest hit is the one that sticks.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (mask[sel_t'(ptr + sel_t'(k))]) begin
        idx   = sel_t'(ptr + sel_t'(k));
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_rr_scheduler.sv
// Round-robin scheduler driving the 8:1 sample-mux select with burst-limited grants
// and a valid/ready handshake toward the downstream consumer.
module mux_rr_scheduler
  import dds_mux_pkg::*;
#(
  parameter int BURST_LEN = 4,
  parameter int CNT_W     = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               out_ready,
  output logic [SEL_W-1:0]   sel,
  output logic [NUM_REQ-1:0] grant,
  output logic               out_valid,
  output logic               busy
);

  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);

  sched_state_t       state_q, state_d;
  sel_t               sel_q, sel_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  sel_t               ptr_q, ptr_d;
  logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;

  logic in_grant;
  logic beat;
  logic release_now;
  sel_t sel_next;
  sel_t pick_ptr;
  sel_t pick_idx;
  logic pick_found;

  assign in_grant    = (state_q == GRANT);
  assign out_valid   = in_grant && req[sel_q];
  assign beat        = out_valid && out_ready;
  // A drained requester releases even under backpressure.
  assign release_now = in_grant && ((beat && (beat_cnt_q == LAST_BEAT)) || !req[sel_q]);
  assign sel_next    = sel_q + 1'b1;
  assign pick_ptr    = in_grant ? sel_next : ptr_q;

  rr_priority_pick u_pick (
    .mask  (req),
    .ptr   (pick_ptr),
    .idx   (pick_idx),
    .found (pick_found)
  );

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    grant_d    = grant_q;
    ptr_d      = ptr_q;
    beat_cnt_d = beat_cnt_q;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          sel_d      = pick_idx;
          grant_d    = onehot(pick_idx);
          beat_cnt_d = '0;
          state_d    = GRANT;
        end
      end
      GRANT: begin
        if (release_now) begin
          ptr_d = sel_next;
          if (pick_found) begin
            sel_d      = pick_idx;
            grant_d    = onehot(pick_idx);
            beat_cnt_d = '0;
          end else begin
            grant_d = '0;
            state_d = IDLE;
          end
        end else if (beat) begin
          beat_cnt_d = beat_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      sel_q      <= '0;
      grant_q    <= '0;
      ptr_q      <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      grant_q    <= grant_d;
      ptr_q      <= ptr_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  assign sel   = sel_q;
  assign grant = grant_q;
  assign busy  = in_grant;

endmodule

// File: tb/tb_mux_rr_scheduler.sv
// Self-checking bench for mux_rr_scheduler: directed scenarios plus randomized traffic vs a behavioural model.
module tb_mux_rr_scheduler;

  localparam int BL = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] req;
  logic       out_ready;
  logic [2:0] sel;
  logic [7:0] grant;
  logic       out_valid;
  logic       busy;

  int vectors = 0;
  int miscompares = 0;

  // Behavioural model: who holds the mux, where the next search starts, beats delivered so far.
  bit m_active = 0;
  int m_cur = 0;
  int m_ptr = 0;
  int m_beats = 0;

  mux_rr_scheduler #(.BURST_LEN(BL), .CNT_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .out_ready (out_ready),
    .sel       (sel),
    .grant     (grant),
    .out_valid (out_valid),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  function automatic int pick(logic [7:0] mask, int start);
    for (int k = 0; k < 8; k++)
      if (mask[(start + k) % 8]) return (start + k) % 8;
    return -1;
  endfunction

  function automatic logic [12:0] want();
    logic [7:0] g;
    g = m_active ? (8'd1 << m_cur) : 8'd0;
    return {3'(m_cur), g, m_active && req[m_cur], m_active};
  endfunction

  task automatic model_step();
    int p;
    bit took;
    if (!rst_n) begin
      m_active = 0; m_cur = 0; m_ptr = 0; m_beats = 0;
    end else if (!m_active) begin
      p = pick(req, m_ptr);
      if (p >= 0) begin m_active = 1; m_cur = p; m_beats = 0; end
    end else begin
      took = req[m_cur] && out_ready;
      if (!req[m_cur] || (took && m_beats + 1 == BL)) begin
        m_ptr = (m_cur + 1) % 8;
        p = pick(req, m_ptr);
        if (p >= 0) begin m_cur = p; m_beats = 0; end
        else m_active = 0;
      end else if (took) begin
        m_beats++;
      end
    end
  endtask

  task automatic drive(input logic rn, input logic [7:0] r, input logic rdy);
    @(negedge clk);
    rst_n = rn; req = r; out_ready = rdy;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
  endtask

  task automatic do_reset();
    drive(1'b0, 8'h00, 1'b0); tick();
    drive(1'b0, 8'h00, 1'b0); tick();
  endtask

  task automatic test_reset();
    logic [12:0] w;
    drive(1'b0, 8'h04, 1'b1); tick();
    drive(1'b0, 8'h04, 1'b1);
    vectors++;
    if ({sel, grant, out_valid, busy} !== 13'h0) begin
      miscompares++;
      $display("FAIL reset_state: got %h want 0000", {sel, grant, out_valid, busy});
    end
    tick();
    for (int c = 0; c < 10; c++) begin
      drive(1'b1, 8'h04, 1'b1);
      w = want();
      vectors++;
      if ({sel, grant, out_valid, busy} !== w) begin
        miscompares++;
        $display("FAIL reset_single c=%0d: got %h want %h", c, {sel, grant, out_valid, busy}, w);
      end
      if (c >= 1) begin
        vectors++;
        if (sel !== 3'd2 || grant !== 8'h04 || out_valid !== 1'b1) begin
          miscompares++;
          $display("FAIL single_req_grant c=%0d: got sel=%0d grant=%h ov=%b want sel=2 grant=04 ov=1", c, sel, grant, out_valid);
        end
      end
      tick();
    end
  endtask

  task automatic test_full_contention();
    logic [12:0] w;
    do_reset();
    drive(1'b1, 8'hFF, 1'b1); tick();
    for (int k = 0; k < 36; k++) begin
      drive(1'b1, 8'hFF, 1'b1);
      w = want();
      vectors++;
      if ({sel, grant, out_valid, busy} !== w || sel !== 3'((k / BL) % 8) || busy !== 1'b1) begin
        miscompares++;
        $display("FAIL full_contention k=%0d: got sel=%0d busy=%b want sel=%0d busy=1 (model %h)", k, sel, busy, (k / BL) % 8, w);
      end
      tick();
    end
  endtask

  task automatic test_early_drain();
    logic [12:0] w;
    logic [7:0] r;
    do_reset();
    drive(1'b1, 8'h11, 1'b1); tick();
    for (int k = 0; k < 8; k++) begin
      r = (k < 2) ? 8'h11 : 8'h10;
      drive(1'b1, r, 1'b1);
      w = want();
      vectors++;
      if ({sel, grant, out_valid, busy} !== w) begin
        miscompares++;
        $display("FAIL early_drain k=%0d: got %h want %h", k, {sel, grant, out_valid, busy}, w);
      end
      if (k >= 3 && k <= 6) begin
        vectors++;
        if (sel !== 3'd4 || grant !== 8'h10 || out_valid !== 1'b1) begin
          miscompares++;
          $display("FAIL drain_regrant k=%0d: got sel=%0d grant=%h want sel=4 grant=10", k, sel, grant);
        end
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    logic [12:0] w;
    do_reset();
    drive(1'b1, 8'h20, 1'b0); tick();
    for (int k = 0; k < 6; k++) begin
      drive(1'b1, 8'h20, 1'b0);
      vectors++;
      if (sel !== 3'd5 || out_valid !== 1'b1 || {sel, grant, out_valid, busy} !== want()) begin
        miscompares++;
        $display("FAIL stall k=%0d: got sel=%0d ov=%b want sel=5 ov=1", k, sel, out_valid);
      end
      tick();
    end
    for (int k = 0; k < 6; k++) begin
      drive(1'b1, 8'h60, 1'b1);
      w = want();
      vectors++;
      if ({sel, grant, out_valid, busy} !== w || sel !== ((k < BL) ? 3'd5 : 3'd6)) begin
        miscompares++;
        $display("FAIL after_stall k=%0d: got %h want %h", k, {sel, grant, out_valid, busy}, w);
      end
      tick();
    end
  endtask

  task automatic test_wrap();
    logic [12:0] w;
    do_reset();
    drive(1'b1, 8'h80, 1'b1); tick();
    for (int c = 0; c < 16; c++) begin
      drive(1'b1, 8'h81, 1'b1);
      w = want();
      vectors++;
      if ({sel, grant, out_valid, busy} !== w || sel !== ((((c / BL) % 2) == 0) ? 3'd7 : 3'd0)) begin
        miscompares++;
        $display("FAIL wrap c=%0d: got %h want %h", c, {sel, grant, out_valid, busy}, w);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid_burst();
    logic [12:0] w;
    do_reset();
    drive(1'b1, 8'h08, 1'b1); tick();
    for (int c = 0; c < 6; c++) begin
      drive((c == 5) ? 1'b0 : 1'b1, 8'h08, 1'b1);
      w = want();
      vectors++;
      if ({sel, grant, out_valid, busy} !== w || sel !== 3'd3) begin
        miscompares++;
        $display("FAIL pre_abort c=%0d: got %h want %h", c, {sel, grant, out_valid, busy}, w);
      end
      tick();
    end
    drive(1'b1, 8'h18, 1'b0);
    vectors++;
    if ({sel, grant, out_valid, busy} !== 13'h0) begin
      miscompares++;
      $display("FAIL abort_state: got %h want 0000", {sel, grant, out_valid, busy});
    end
    tick();
    drive(1'b1, 8'h18, 1'b0);
    vectors++;
    if (sel !== 3'd3 || grant !== 8'h08 || {sel, grant, out_valid, busy} !== want()) begin
      miscompares++;
      $display("FAIL ptr_after_reset: got sel=%0d grant=%h want sel=3 grant=08", sel, grant);
    end
    tick();
  endtask

  task automatic test_random();
    logic [12:0] w;
    logic [7:0] r;
    logic rn;
    logic rdy;
    r = 8'h00;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      r  = r ^ 8'($urandom & $urandom & $urandom);
      rdy = ($urandom_range(0, 3) != 0);
      rn  = ($urandom_range(0, 63) != 0);
      drive(rn, r, rdy);
      w = want();
      vectors++;
      if ({sel, grant, out_valid, busy} !== w) begin
        miscompares++;
        $display("FAIL random c=%0d req=%h rdy=%b: got %h want %h", c, r, rdy, {sel, grant, out_valid, busy}, w);
      end
      tick();
    end
  endtask

  initial begin
    rst_n = 1'b0;
    req = 8'h00;
    out_ready = 1'b0;
    test_reset();
    test_full_contention();
    test_early_drain();
    test_backpressure();
    test_wrap();
    test_reset_mid_burst();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mux_rr_scheduler.md
Name: mux_rr_scheduler

Overview:
- Round-robin scheduler that shares the 8-input, 8-bit sample mux between 8 requesters (DDS channels or pattern sources) and drives its 3-bit select.
- Grants one requester at a time for a burst of up to BURST_LEN accepted beats.
- Presents a valid/ready handshake toward the downstream consumer, which is the DAC formatter or an output FIFO.
- Sits directly beside the mux. The mux data path stays outside this block.

Parameters:
- BURST_LEN, 4, maximum beats per grant. Legal range 1..15.
- CNT_W, 4, width of the beat counter. Must satisfy 2^CNT_W > BURST_LEN.

Ports:
- clk  in  1  system clock; all logic is on its rising edge.
- rst_n  in  1  synchronous, active-low reset.
- req  in  8  per-requester "data available" level. req[i] drives mux input i.
- out_ready  in  1  downstream accepts the current beat.
- sel  out  3  mux select, registered.
- grant  out  8  one-hot grant, registered. All-zero when idle.
- out_valid  out  1  current mux output is a valid beat.
- busy  out  1  high while in the GRANT state.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=IDLE, sel=0, grant=0, ptr=0, beat_cnt=0.
  - out_valid=0 and busy=0.
  - Reset mid-burst aborts the burst immediately. No beat is counted on the reset edge.
- States are IDLE and GRANT.
- Arbitration function pick(mask, ptr):
  - Returns the first index i with mask[i]=1, searching ptr, ptr+1, ... ptr+7, wrapping mod 8.
  - Also returns a found flag.
- IDLE:
  - If |req, on the next edge load sel=pick(req,ptr), load grant=onehot(sel), clear beat_cnt, and go to GRANT.
  - Latency from req rising to grant is 1 cycle.
- GRANT:
  - out_valid = req[sel], combinational. The block does not register the data.
  - A beat is out_valid && out_ready. Each beat increments beat_cnt.
  - Release occurs on either condition:
    - (a) a beat while beat_cnt == BURST_LEN-1;
    - (b) req[sel]==0 at the edge (requester drained).
  - On release, ptr <= sel+1 (mod 8). Then re-arbitrate at the same edge:
    - If pick(req,sel+1) finds a requester, load the new sel/grant, clear beat_cnt, and stay in GRANT. There is no bubble cycle.
    - If nothing is found, go to IDLE and set grant=0. sel holds its last value.
  - For condition (b), req[sel] is 0 and is therefore excluded automatically.
  - For condition (a), the same requester is re-granted only if it is the sole requester, because it is searched last.
- Stability:
  - sel and grant change only on release or when leaving IDLE.
  - sel never changes while out_valid=1 && out_ready=0.
- Requester rule: req[i] stays high until its beat is accepted. The scheduler does not check this rule. A dropped req simply ends the burst.
- Fairness: with all 8 requesting continuously, grants rotate 0,1,...,7,0. Each grant delivers exactly BURST_LEN beats when out_ready=1.
- Simultaneous events:
  - A new req arriving on the release edge takes part in that edge's pick.
  - Backpressure (out_ready=0) freezes beat_cnt but not the release on req drop.
- BURST_LEN=1: every accepted beat releases the grant. This is per-sample interleaving.

Decomposition:
- Package dds_mux_pkg contains:
  - NUM_REQ=8 and SEL_W=3;
  - typedef sched_state_t {IDLE, GRANT};
  - typedef sel_t logic[SEL_W-1:0].
- Sub-module rr_priority_pick is purely combinational. Inputs are mask[7:0] and ptr[2:0]; outputs are idx[2:0] and found. It is instantiated once and fed either req or the release-time request vector.
- The top level holds the FSM, ptr, beat_cnt and the output registers.

Test Plan:
- Reset then a single requester:
  - Stimulus: rst_n=0 for 2 cycles with req=8'h04, then rst_n=1.
  - Response: grant=8'h04 and sel=2 one cycle later. out_valid=1. With out_ready=1, release after 4 beats, then immediate re-grant to requester 2, which is the sole requester.
- Full contention:
  - Stimulus: req=8'hFF, out_ready=1, BURST_LEN=4.
  - Response: sel sequence 0×4, 1×4, ... 7×4, then 0. No idle cycles between grants.
- Early drain:
  - Stimulus: req=8'h11 with requester 0 granted; drop req[0] after 2 beats.
  - Response: at the next edge sel=4 and grant=8'h10. beat_cnt restarts, and requester 4 receives a full 4 beats.
- Backpressure:
  - Stimulus: requester 5 granted; out_ready=0 for 6 cycles, then 1.
  - Response: sel=5 stable and beat_cnt frozen while stalled. Release occurs only after 4 accepted beats.
- Wrap and pointer:
  - Stimulus: grant on requester 7 ends; req=8'h81.
  - Response: next grant is requester 0, then requester 7, alternating.
- Reset mid-burst:
  - Stimulus: rst_n=0 during beat 2 of requester 3's grant.
  - Response: next cycle grant=0, out_valid=0, busy=0, sel=0. After release from reset, arbitration restarts with ptr=0.
